// File: rtl/stream_demux_2.sv
// stream_demux_2: 1-to-2 packet demultiplexer with a one-beat slice per output.
// Optional packet counters are enabled by defining STREAM_DEMUX_PKT_CNT_EN.
module stream_demux_2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              sel,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_a_valid,
    output logic              out_a_last,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic              out_b_valid,
    output logic              out_b_last,
    input  logic              out_b_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt_a,
    output logic [CNT_W-1:0]  pkt_cnt_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT_A = 2'd1,
        PKT_B = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_a_valid;
    logic              r_a_last;
    logic [DATA_W-1:0] r_a_data;
    logic              r_b_valid;
    logic              r_b_last;
    logic [DATA_W-1:0] r_b_data;

    logic w_free_a;
    logic w_free_b;
    logic w_dest_b;
    logic w_ready;
    logic w_acc;
    logic w_load_a;
    logic w_load_b;

    // A slot is free when empty or draining this cycle, giving full rate.
    assign w_free_a = !r_a_valid || out_a_ready;
    assign w_free_b = !r_b_valid || out_b_ready;

    // Destination follows sel only between packets; locked otherwise.
    always_comb begin
        w_dest_b = sel;
        case (r_state)
            IDLE:    w_dest_b = sel;
            PKT_A:   w_dest_b = 1'b0;
            PKT_B:   w_dest_b = 1'b1;
            default: w_dest_b = sel;
        endcase
    end

    assign w_ready  = sys_rst_n && (w_dest_b ? w_free_b : w_free_a);
    assign w_acc    = in_valid && w_ready;
    assign w_load_a = w_acc && !w_dest_b;
    assign w_load_b = w_acc && w_dest_b;

    // Next-state logic: open a packet on a non-last beat, close on last.
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                IDLE: begin
                    if (!in_last)
                        w_state_nxt = sel ? PKT_B : PKT_A;
                end
                PKT_A, PKT_B: begin
                    if (in_last)
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Output A slice: load replaces, drain clears valid, stall holds.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_a_data  <= '0;
        end else if (w_load_a) begin
            r_a_valid <= 1'b1;
            r_a_last  <= in_last;
            r_a_data  <= in_data;
        end else if (out_a_ready) begin
            r_a_valid <= 1'b0;
        end
    end

    // Output B slice: load replaces, drain clears valid, stall holds.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_b_valid <= 1'b0;
            r_b_last  <= 1'b0;
            r_b_data  <= '0;
        end else if (w_load_b) begin
            r_b_valid <= 1'b1;
            r_b_last  <= in_last;
            r_b_data  <= in_data;
        end else if (out_b_ready) begin
            r_b_valid <= 1'b0;
        end
    end

`ifdef STREAM_DEMUX_PKT_CNT_EN
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    // Count delivered packets: handshake on a last beat, wrapping.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (r_a_valid && out_a_ready && r_a_last)
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (r_b_valid && out_b_ready && r_b_last)
                r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    assign pkt_cnt_a = r_cnt_a;
    assign pkt_cnt_b = r_cnt_b;
`else
    assign pkt_cnt_a = '0;
    assign pkt_cnt_b = '0;
`endif

    assign in_ready    = w_ready;
    assign out_a_data  = r_a_data;
    assign out_a_valid = r_a_valid;
    assign out_a_last  = r_a_last;
    assign out_b_data  = r_b_data;
    assign out_b_valid = r_b_valid;
    assign out_b_last  = r_b_last;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_stream_demux_2.sv
// tb_stream_demux_2: scenario tasks plus a cycle-level reference model
// and per-output ordered scoreboards for stream_demux_2.
module tb_stream_demux_2;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          sel;
    logic [DW-1:0] out_a_data;
    logic          out_a_valid;
    logic          out_a_last;
    logic          out_a_ready;
    logic [DW-1:0] out_b_data;
    logic          out_b_valid;
    logic          out_b_last;
    logic          out_b_ready;
    logic          busy;
    logic [CW-1:0] pkt_cnt_a;
    logic [CW-1:0] pkt_cnt_b;

    stream_demux_2 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .sel         (sel),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_last  (out_a_last),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_last  (out_b_last),
        .out_b_ready (out_b_ready),
        .busy        (busy),
        .pkt_cnt_a   (pkt_cnt_a),
        .pkt_cnt_b   (pkt_cnt_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    int to_cnt  = 0;

    // reference model: packet lock (0 none, 1 A, 2 B) and one slot per output
    int            m_lock = 0;
    logic          ma_v = 0, ma_l = 0, mb_v = 0, mb_l = 0;
    logic [DW-1:0] ma_d = '0, mb_d = '0;
    logic [CW-1:0] m_cnt_a = '0, m_cnt_b = '0;
    logic [DW:0]   q_a[$];
    logic [DW:0]   q_b[$];

    initial begin
        logic          m_dest_b;
        logic          m_rdy;
        logic [CW-1:0] e_ca;
        logic [CW-1:0] e_cb;
        logic [25:0]   got;
        logic [25:0]   exp;
        logic [DW:0]   e;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!sys_rst_n) begin
                m_lock = 0;
                ma_v = 0; ma_l = 0; ma_d = '0;
                mb_v = 0; mb_l = 0; mb_d = '0;
                m_cnt_a = '0; m_cnt_b = '0;
                q_a.delete();
                q_b.delete();
            end
            m_dest_b = (m_lock == 0) ? sel : (m_lock == 2);
            m_rdy = sys_rst_n &&
                (m_dest_b ? (!mb_v || out_b_ready) : (!ma_v || out_a_ready));
`ifdef STREAM_DEMUX_PKT_CNT_EN
            e_ca = m_cnt_a;
            e_cb = m_cnt_b;
`else
            e_ca = '0;
            e_cb = '0;
`endif
            exp = {m_rdy, m_lock != 0, ma_v, ma_l, ma_d,
                   mb_v, mb_l, mb_d, e_ca, e_cb};
            got = {in_ready, busy, out_a_valid, out_a_last, out_a_data,
                   out_b_valid, out_b_last, out_b_data, pkt_cnt_a, pkt_cnt_b};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cycle_state cyc=%0d got=%h expected=%h",
                         cyc, got, exp);
            end
            if (sys_rst_n) begin
                if (out_a_valid === 1'b1 && out_a_ready) begin
                    n_tests++;
                    if (q_a.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_a cyc=%0d got=%h expected=none",
                                 cyc, {out_a_last, out_a_data});
                    end else begin
                        e = q_a.pop_front();
                        if ({out_a_last, out_a_data} !== e) begin
                            n_fail++;
                            $display("FAIL sb_a cyc=%0d got=%h expected=%h",
                                     cyc, {out_a_last, out_a_data}, e);
                        end
                    end
                end
                if (out_b_valid === 1'b1 && out_b_ready) begin
                    n_tests++;
                    if (q_b.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_b cyc=%0d got=%h expected=none",
                                 cyc, {out_b_last, out_b_data});
                    end else begin
                        e = q_b.pop_front();
                        if ({out_b_last, out_b_data} !== e) begin
                            n_fail++;
                            $display("FAIL sb_b cyc=%0d got=%h expected=%h",
                                     cyc, {out_b_last, out_b_data}, e);
                        end
                    end
                end
                if (ma_v && out_a_ready) begin
                    ma_v = 0;
                    if (ma_l) m_cnt_a = m_cnt_a + 1'b1;
                end
                if (mb_v && out_b_ready) begin
                    mb_v = 0;
                    if (mb_l) m_cnt_b = m_cnt_b + 1'b1;
                end
                if (in_valid && m_rdy) begin
                    acc_cnt++;
                    if (m_dest_b) begin
                        mb_v = 1; mb_l = in_last; mb_d = in_data;
                        q_b.push_back({in_last, in_data});
                    end else begin
                        ma_v = 1; ma_l = in_last; ma_d = in_data;
                        q_a.push_back({in_last, in_data});
                    end
                    if (m_lock == 0) begin
                        if (!in_last) m_lock = m_dest_b ? 2 : 1;
                    end else if (in_last) begin
                        m_lock = 0;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l,
                             input logic s);
        int start;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sel      = s;
        start    = acc_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk);
            #2;
            if (acc_cnt != start) begin
                in_valid = 1'b0;
                return;
            end
        end
        to_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, out_a_valid, out_b_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b expected=0000",
                     {in_ready, busy, out_a_valid, out_b_valid});
        end
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single_beats;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        send_beat(8'h11, 1'b1, 1'b0);
        n_tests++;
        if ({out_a_valid, out_a_data, out_b_valid} !== {1'b1, 8'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL single_a got=%b/%h/%b expected=1/11/0",
                     out_a_valid, out_a_data, out_b_valid);
        end
        send_beat(8'h22, 1'b1, 1'b1);
        n_tests++;
        if ({out_b_valid, out_b_data, out_a_valid} !== {1'b1, 8'h22, 1'b0}) begin
            n_fail++;
            $display("FAIL single_b got=%b/%h/%b expected=1/22/0",
                     out_b_valid, out_b_data, out_a_valid);
        end
        idle(2);
    endtask

    task automatic test_packet_lock;
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            send_beat(d, i == 3, 1'(i));
            n_tests++;
            if (busy !== (i != 3) || out_a_data !== d || out_a_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL lock_beat%0d got=busy%b/%h/%b expected=busy%b/%h/%b",
                         i, busy, out_a_data, out_a_last, i != 3, d, i == 3);
            end
        end
        idle(2);
    endtask

    task automatic test_stall_hold;
        out_a_ready = 1'b0;
        send_beat(8'hC0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hC1;
        in_last  = 1'b0;
        sel      = 1'b1;
        repeat (5) begin
            idle(1);
            n_tests++;
            if ({in_ready, out_a_valid, out_a_last, out_a_data} !==
                {1'b0, 1'b1, 1'b0, 8'hC0}) begin
                n_fail++;
                $display("FAIL stall_hold got=%b/%b/%b/%h expected=0/1/0/c0",
                         in_ready, out_a_valid, out_a_last, out_a_data);
            end
        end
        out_a_ready = 1'b1;
        send_beat(8'hC1, 1'b0, 1'b1);
        send_beat(8'hC2, 1'b1, 1'b1);
        idle(3);
        n_tests++;
        if (q_a.size() != 0 || out_a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain got=pending%0d/v%b expected=0/0",
                     q_a.size(), out_a_valid);
        end
    endtask

    task automatic test_independent;
        int t0;
        out_a_ready = 1'b0;
        out_b_ready = 1'b1;
        send_beat(8'h55, 1'b1, 1'b0);
        t0 = cyc;
        for (int i = 0; i < 3; i++)
            send_beat(8'hB0 + 8'(i), i == 2, 1'b1);
        n_tests++;
        if (cyc - t0 != 3 || out_a_valid !== 1'b1 || out_a_data !== 8'h55) begin
            n_fail++;
            $display("FAIL independent got=cycles%0d/%b/%h expected=3/1/55",
                     cyc - t0, out_a_valid, out_a_data);
        end
        out_a_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back;
        int t0;
        out_b_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            send_beat(8'hD0 + 8'(i), i == 7, 1'b1);
        n_tests++;
        if (cyc - t0 != 8) begin
            n_fail++;
            $display("FAIL back_to_back got=%0d cycles expected=8", cyc - t0);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++)
            send_beat(8'hE0 + 8'(i), 1'b0, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, out_a_valid, out_b_valid, in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid got=%b expected=0000",
                     {busy, out_a_valid, out_b_valid, in_ready});
        end
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
        send_beat(8'h77, 1'b1, 1'b1);
        n_tests++;
        if ({out_b_valid, out_b_data, out_a_valid, busy} !==
            {1'b1, 8'h77, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_route got=%b/%h/%b/%b expected=1/77/0/0",
                     out_b_valid, out_b_data, out_a_valid, busy);
        end
        idle(2);
    endtask

    task automatic test_counter_wrap;
        logic [CW-1:0] e_a;
        sys_rst_n = 1'b0;
        idle(1);
        sys_rst_n = 1'b1;
        out_a_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send_beat(8'h30 + 8'(i), 1'b1, 1'b0);
        idle(2);
`ifdef STREAM_DEMUX_PKT_CNT_EN
        e_a = 2'd1;
`else
        e_a = 2'd0;
`endif
        n_tests++;
        if (pkt_cnt_a !== e_a || pkt_cnt_b !== 2'd0) begin
            n_fail++;
            $display("FAIL counter_wrap got=%0d/%0d expected=%0d/0",
                     pkt_cnt_a, pkt_cnt_b, e_a);
        end
    endtask

    task automatic test_random;
        bit done;
        done = 1'b0;
        fork
            begin
                int len;
                logic s;
                for (int p = 0; p < 300; p++) begin
                    len = $urandom_range(1, 4);
                    s   = 1'($urandom);
                    for (int b = 0; b < len; b++)
                        send_beat(8'($urandom), b == len - 1,
                                  (b == 0) ? s : 1'($urandom));
                    idle($urandom_range(0, 1));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_a_ready = ($urandom % 4) != 0;
                    out_b_ready = ($urandom % 3) != 0;
                    idle(1);
                end
            end
        join
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        idle(4);
        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0 || to_cnt != 0) begin
            n_fail++;
            $display("FAIL random_drain got=pa%0d/pb%0d/to%0d expected=0/0/0",
                     q_a.size(), q_b.size(), to_cnt);
        end
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        sel         = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        @(posedge sys_clk);
        #2;
        test_reset();
        test_single_beats();
        test_packet_lock();
        test_stall_hold();
        test_independent();
        test_back_to_back();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
